// File: rtl/tdes_pkg.sv
// Shared types and constants for the triple-DES pass sequencer.
package tdes_pkg;

  localparam int unsigned DES_BLOCK_W = 64;
  localparam int unsigned DES_KEY_W   = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_OUTPUT
  } tdes_state_e;

  typedef logic [1:0] pass_t;

  localparam pass_t LAST_PASS = 2'd2;

  // Key used on a given pass: encrypt walks key_1..key_3, decrypt walks key_3..key_1.
  function automatic logic [DES_KEY_W-1:0] pass_key(
    input pass_t                p,
    input logic                 dec,
    input logic [DES_KEY_W-1:0] k1,
    input logic [DES_KEY_W-1:0] k2,
    input logic [DES_KEY_W-1:0] k3
  );
    logic [DES_KEY_W-1:0] k;
    k = k2;
    if (p == 2'd0) k = dec ? k3 : k1;
    else if (p == 2'd2) k = dec ? k1 : k3;
    return k;
  endfunction

endpackage

// File: rtl/triple_des_sequencer.sv
// Drives a shared single-DES engine through three passes (EDE encrypt / DED decrypt).
module triple_des_sequencer
  import tdes_pkg::*;
#(
  parameter int unsigned DONE_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DES_BLOCK_W-1:0] data_in,
  input  logic [DES_KEY_W-1:0]   key_1,
  input  logic [DES_KEY_W-1:0]   key_2,
  input  logic [DES_KEY_W-1:0]   key_3,
  input  logic                   decrypt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DES_BLOCK_W-1:0] data_out,
  output logic                   error,
  output logic                   des_start,
  output logic [DES_BLOCK_W-1:0] des_data,
  output logic [DES_KEY_W-1:0]   des_key,
  output logic                   des_decrypt,
  input  logic                   des_done,
  input  logic [DES_BLOCK_W-1:0] des_result
);

  localparam int unsigned CNT_W = $clog2(DONE_TIMEOUT + 1);

  tdes_state_e            state_q, state_d;
  pass_t                  pass_q, pass_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DES_BLOCK_W-1:0] blk_q, blk_d;
  logic [DES_KEY_W-1:0]   k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic                   dec_q, dec_d;

  // State, pass index, timeout counter and captured block/keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pass_q  <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
      k1_q    <= '0;
      k2_q    <= '0;
      k3_q    <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      k3_q    <= k3_d;
      dec_q   <= dec_d;
    end
  end

  // Next-state logic and handshake/control outputs.
  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    k1_d      = k1_q;
    k2_d      = k2_q;
    k3_d      = k3_q;
    dec_d     = dec_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    des_start = 1'b0;
    error     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d   = data_in;
          k1_d    = key_1;
          k2_d    = key_2;
          k3_d    = key_3;
          dec_d   = decrypt;
          pass_d  = '0;
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        des_start = 1'b1;
        // First WAIT cycle is one cycle after des_start.
        cnt_d     = CNT_W'(1);
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (des_done) begin
          blk_d = des_result;
          cnt_d = '0;
          if (pass_q == LAST_PASS) begin
            state_d = ST_OUTPUT;
          end else begin
            pass_d  = pass_q + 2'd1;
            state_d = ST_START;
          end
        end else if (cnt_q >= CNT_W'(DONE_TIMEOUT)) begin
          error   = 1'b1;
          blk_d   = '0;
          pass_d  = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Engine operands come straight from registers, so they hold until des_done.
  always_comb begin
    data_out    = blk_q;
    des_data    = blk_q;
    des_key     = pass_key(pass_q, dec_q, k1_q, k2_q, k3_q);
    des_decrypt = dec_q ^ (pass_q == 2'd1);
  end

endmodule

// File: tb/tb_triple_des_sequencer.sv
// Self-checking bench for triple_des_sequencer with a behavioural DES engine stand-in.
module tb_triple_des_sequencer;

  localparam int unsigned TMO = 64;
  localparam logic [63:0] K0 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C0 = 64'h85E813540F0AB405;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [63:0] data_in, key_1, key_2, key_3;
  logic        decrypt;
  logic        out_valid, out_ready;
  logic [63:0] data_out;
  logic        error;
  logic        des_start;
  logic [63:0] des_data, des_key;
  logic        des_decrypt;
  logic        des_done;
  logic [63:0] des_result;

  triple_des_sequencer #(.DONE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .key_1(key_1), .key_2(key_2), .key_3(key_3),
    .decrypt(decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .error(error),
    .des_start(des_start), .des_data(des_data), .des_key(des_key),
    .des_decrypt(des_decrypt), .des_done(des_done), .des_result(des_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Single-DES stand-in: known-answer vector for K0, otherwise an invertible toy cipher.
  function automatic logic [63:0] toy_e(input logic [63:0] k, input logic [63:0] x);
    logic [63:0] t;
    if (k == K0 && x == P0) return C0;
    t = x ^ k;
    return {t[50:0], t[63:51]};
  endfunction

  function automatic logic [63:0] toy_d(input logic [63:0] k, input logic [63:0] x);
    logic [63:0] t;
    if (k == K0 && x == C0) return P0;
    t = {x[12:0], x[63:13]};
    return t ^ k;
  endfunction

  // Triple-DES composition straight from the EDE/DED definition.
  function automatic logic [63:0] ref_tdes(input logic [63:0] p, input logic [63:0] k1,
                                           input logic [63:0] k2, input logic [63:0] k3,
                                           input logic dec);
    if (dec) return toy_d(k1, toy_e(k2, toy_d(k3, p)));
    return toy_e(k3, toy_d(k2, toy_e(k1, p)));
  endfunction

  // Engine model state
  int          eng_lat = 3;
  bit          eng_on = 1'b1;
  bit          chk_stable = 1'b1;
  int          n_start = 0;
  int          start_cyc = 0;
  logic [63:0] sk[$];
  bit          sd[$];

  initial begin
    automatic bit          pend = 1'b0;
    automatic int          cnt = 0;
    automatic logic [63:0] cap_x = '0, cap_k = '0;
    automatic logic        cap_dec = 1'b0;
    des_done   = 1'b0;
    des_result = '0;
    forever begin
      @(negedge clk);
      des_done = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend       = 1'b0;
          des_done   = 1'b1;
          des_result = cap_dec ? toy_d(cap_k, cap_x) : toy_e(cap_k, cap_x);
          if (chk_stable) begin
            checks++;
            if (des_data !== cap_x || des_key !== cap_k || des_decrypt !== cap_dec) begin
              errors++;
              $display("FAIL engine_operands_stable: got %h/%h/%b expected %h/%h/%b",
                       des_data, des_key, des_decrypt, cap_x, cap_k, cap_dec);
            end
          end
        end
      end
      if (des_start === 1'b1) begin
        n_start++;
        start_cyc = cyc;
        sk.push_back(des_key);
        sd.push_back(des_decrypt);
        if (eng_on) begin
          pend    = 1'b1;
          cnt     = eng_lat;
          cap_x   = des_data;
          cap_k   = des_key;
          cap_dec = des_decrypt;
        end
      end
    end
  end

  int hs_cyc, out_cyc, start_base;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one block, wait for acceptance and for out_valid; returns in the first OUTPUT cycle.
  task automatic run_block(input logic [63:0] d, input logic [63:0] k1, input logic [63:0] k2,
                           input logic [63:0] k3, input logic dec, output logic [63:0] res);
    int bound;
    data_in = d; key_1 = k1; key_2 = k2; key_3 = k3; decrypt = dec;
    in_valid = 1'b1;
    sk.delete();
    sd.delete();
    start_base = n_start;
    bound = 0;
    while (in_ready !== 1'b1 && bound < 300) begin step(); bound++; end
    if (bound >= 300) begin
      checks++; errors++;
      $display("FAIL accept_wait: in_ready never rose within %0d cycles", bound);
      in_valid = 1'b0;
      res = 'x;
      return;
    end
    hs_cyc = cyc;
    step();
    in_valid = 1'b0;
    bound = 0;
    while (out_valid !== 1'b1 && bound < 300) begin step(); bound++; end
    if (bound >= 300) begin
      checks++; errors++;
      $display("FAIL output_wait: out_valid never rose within %0d cycles", bound);
      res = 'x;
      return;
    end
    out_cyc = cyc;
    res = data_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    data_in = '0; key_1 = '0; key_2 = '0; key_3 = '0; decrypt = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({in_ready, out_valid, des_start, error, des_decrypt} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_controls: got %b expected 10000",
               {in_ready, out_valid, des_start, error, des_decrypt});
    end
    checks++;
    if (data_out !== 64'h0 || des_data !== 64'h0 || des_key !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h/%h expected zero", data_out, des_data, des_key);
    end
  endtask

  task automatic test_kat();
    logic [63:0] res;
    logic [63:0] ek[3];
    bit          ed[3];
    eng_lat = 3;
    for (int unsigned dir = 0; dir < 2; dir++) begin
      run_block(dir == 0 ? P0 : C0, K0, K0, K0, dir[0], res);
      checks++;
      if (res !== (dir == 0 ? C0 : P0)) begin
        errors++;
        $display("FAIL kat_dir%0d: got %h expected %h", dir, res, dir == 0 ? C0 : P0);
      end
      ek[0] = K0; ek[1] = K0; ek[2] = K0;
      ed[0] = dir[0]; ed[1] = ~dir[0]; ed[2] = dir[0];
      checks++;
      if (sk.size() != 3) begin
        errors++;
        $display("FAIL kat_start_count: got %0d expected 3", sk.size());
      end
      for (int i = 0; i < 3 && i < sk.size(); i++) begin
        checks++;
        if (sk[i] !== ek[i] || sd[i] !== ed[i]) begin
          errors++;
          $display("FAIL kat_sched_pass%0d: got %h/%b expected %h/%b", i, sk[i], sd[i], ek[i], ed[i]);
        end
      end
      step();
    end
  endtask

  task automatic test_latency();
    logic [63:0] res, d;
    logic [63:0] k1, k2, k3;
    k1 = 64'h9474B8E8C73BCA7D; k2 = 64'h8DA744E0C94E5E17; k3 = 64'h0CDB25E3BA3C6D79;
    d = {$urandom, $urandom};
    eng_lat = 5;
    run_block(d, k1, k2, k3, 1'b0, res);
    checks++;
    if (n_start - start_base != 3) begin
      errors++;
      $display("FAIL lat5_starts: got %0d expected 3", n_start - start_base);
    end
    checks++;
    if (out_cyc - hs_cyc != 19) begin
      errors++;
      $display("FAIL lat5_latency: got %0d expected 19", out_cyc - hs_cyc);
    end
    checks++;
    if (res !== ref_tdes(d, k1, k2, k3, 1'b0)) begin
      errors++;
      $display("FAIL lat5_result: got %h expected %h", res, ref_tdes(d, k1, k2, k3, 1'b0));
    end
    step();
  endtask

  task automatic test_random();
    logic [63:0] res, d, k1, k2, k3;
    logic        dec;
    logic [63:0] ek[3];
    for (int it = 0; it < 6; it++) begin
      d = {$urandom, $urandom}; k1 = {$urandom, $urandom};
      k2 = {$urandom, $urandom}; k3 = {$urandom, $urandom};
      dec = $urandom_range(0, 1) == 1;
      eng_lat = $urandom_range(1, 6);
      run_block(d, k1, k2, k3, dec, res);
      checks++;
      if (res !== ref_tdes(d, k1, k2, k3, dec)) begin
        errors++;
        $display("FAIL rand%0d_result: got %h expected %h", it, res, ref_tdes(d, k1, k2, k3, dec));
      end
      checks++;
      if (out_cyc - hs_cyc != 3 * (eng_lat + 1) + 1) begin
        errors++;
        $display("FAIL rand%0d_latency: got %0d expected %0d", it, out_cyc - hs_cyc, 3 * (eng_lat + 1) + 1);
      end
      ek[0] = dec ? k3 : k1; ek[1] = k2; ek[2] = dec ? k1 : k3;
      for (int i = 0; i < 3 && i < sk.size(); i++) begin
        checks++;
        if (sk[i] !== ek[i] || sd[i] !== (dec ^ (i == 1))) begin
          errors++;
          $display("FAIL rand%0d_sched_pass%0d: got %h/%b expected %h/%b",
                   it, i, sk[i], sd[i], ek[i], dec ^ (i == 1));
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ra, rb, a, b, k;
    int          hs1;
    eng_lat = 2;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; k = {$urandom, $urandom};
    run_block(a, k, ~k, k ^ 64'h5A5A, 1'b0, ra);
    hs1 = hs_cyc;
    run_block(b, k, ~k, k ^ 64'h5A5A, 1'b1, rb);
    checks++;
    if (hs_cyc - hs1 != 3 * (eng_lat + 1) + 2) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d expected %0d", hs_cyc - hs1, 3 * (eng_lat + 1) + 2);
    end
    checks++;
    if (ra !== ref_tdes(a, k, ~k, k ^ 64'h5A5A, 1'b0) || rb !== ref_tdes(b, k, ~k, k ^ 64'h5A5A, 1'b1)) begin
      errors++;
      $display("FAIL b2b_results: got %h/%h expected %h/%h", ra, rb,
               ref_tdes(a, k, ~k, k ^ 64'h5A5A, 1'b0), ref_tdes(b, k, ~k, k ^ 64'h5A5A, 1'b1));
    end
    step();
  endtask

  task automatic test_stall();
    logic [63:0] ra, rb, a, b, k1, k2, k3, ea;
    int          o, n0;
    eng_lat = 4;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    k1 = {$urandom, $urandom}; k2 = {$urandom, $urandom}; k3 = {$urandom, $urandom};
    ea = ref_tdes(a, k1, k2, k3, 1'b0);
    out_ready = 1'b0;
    run_block(a, k1, k2, k3, 1'b0, ra);
    o = cyc;
    n0 = n_start;
    data_in = b; decrypt = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || data_out !== ea || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: got ov=%b dout=%h rdy=%b expected ov=1 dout=%h rdy=0",
                 i, out_valid, data_out, in_ready, ea);
      end
      step();
    end
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got rdy=%b ov=%b expected rdy=0 ov=1", in_ready, out_valid);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || n_start != n0) begin
      errors++;
      $display("FAIL stall_after: got rdy=%b ov=%b starts=%0d expected rdy=1 ov=0 starts=%0d",
               in_ready, out_valid, n_start, n0);
    end
    run_block(b, k1, k2, k3, 1'b1, rb);
    checks++;
    if (hs_cyc != o + 11 || rb !== ref_tdes(b, k1, k2, k3, 1'b1)) begin
      errors++;
      $display("FAIL stall_held_block: got hs=%0d res=%h expected hs=%0d res=%h",
               hs_cyc, rb, o + 11, ref_tdes(b, k1, k2, k3, 1'b1));
    end
    step();
  endtask

  task automatic test_timeout();
    int bound, err_cyc, base;
    bit saw_ov;
    eng_on = 1'b0;
    data_in = {$urandom, $urandom}; decrypt = 1'b0; in_valid = 1'b1;
    base = n_start;
    bound = 0;
    while (in_ready !== 1'b1 && bound < 50) begin step(); bound++; end
    step();
    in_valid = 1'b0;
    saw_ov = 1'b0;
    bound = 0;
    while (error !== 1'b1 && bound < 200) begin
      if (out_valid === 1'b1) saw_ov = 1'b1;
      step();
      bound++;
    end
    err_cyc = cyc;
    checks++;
    if (bound >= 200 || err_cyc - start_cyc != TMO || n_start - base != 1) begin
      errors++;
      $display("FAIL timeout_pulse: got delay=%0d starts=%0d expected delay=%0d starts=1",
               err_cyc - start_cyc, n_start - base, TMO);
    end
    step();
    checks++;
    if (error !== 1'b0 || in_ready !== 1'b1 || saw_ov || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: got err=%b rdy=%b ov_seen=%b expected err=0 rdy=1 ov_seen=0",
               error, in_ready, saw_ov | out_valid);
    end
    eng_on = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [63:0] res, d, k1, k2, k3;
    int          bound, base;
    bit          saw;
    eng_lat = 8;
    chk_stable = 1'b0;
    data_in = {$urandom, $urandom}; key_1 = {$urandom, $urandom};
    key_2 = {$urandom, $urandom}; key_3 = {$urandom, $urandom};
    decrypt = 1'b1; in_valid = 1'b1;
    base = n_start;
    bound = 0;
    while (in_ready !== 1'b1 && bound < 50) begin step(); bound++; end
    step();
    in_valid = 1'b0;
    bound = 0;
    while (n_start - base < 2 && bound < 100) begin step(); bound++; end
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, des_start, error, des_decrypt} !== 4'b0000 ||
        data_out !== 64'h0 || des_data !== 64'h0 || des_key !== 64'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b %h/%h/%h expected 0000 zero",
               {out_valid, des_start, error, des_decrypt}, data_out, des_data, des_key);
    end
    step();
    step();
    rst_n = 1'b1;
    base = n_start;
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid === 1'b1 || error === 1'b1) saw = 1'b1;
    end
    checks++;
    if (saw || n_start != base || in_ready !== 1'b1 || des_key !== 64'h0 || data_out !== 64'h0) begin
      errors++;
      $display("FAIL midreset_late_done: got seen=%b starts=%0d rdy=%b key=%h dout=%h expected 0 0 1 zero zero",
               saw, n_start - base, in_ready, des_key, data_out);
    end
    chk_stable = 1'b1;
    eng_lat = 3;
    d = {$urandom, $urandom}; k1 = {$urandom, $urandom};
    k2 = {$urandom, $urandom}; k3 = {$urandom, $urandom};
    run_block(d, k1, k2, k3, 1'b0, res);
    checks++;
    if (res !== ref_tdes(d, k1, k2, k3, 1'b0)) begin
      errors++;
      $display("FAIL midreset_next_block: got %h expected %h", res, ref_tdes(d, k1, k2, k3, 1'b0));
    end
    step();
  endtask

  initial begin
    test_reset();
    test_kat();
    test_latency();
    test_random();
    test_back_to_back();
    test_stall();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/triple_des_sequencer.md
TRIPLE_DES_SEQUENCER -- requirements
Module: triple_des_sequencer

Interface
REQ-001 Parameter DONE_TIMEOUT, default 64: maximum cycles to wait for des_done per pass before aborting.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  block offered on data_in/key_1/key_2/key_3/decrypt.
REQ-005 in_ready  output  1  sequencer accepts a block this cycle.
REQ-006 data_in  input  64  plaintext or ciphertext block.
REQ-007 key_1, key_2, key_3  input  64 each  3DES keys, parity bits ignored.
REQ-008 decrypt  input  1  0 = EDE encrypt, 1 = DED decrypt.
REQ-009 out_valid  output  1  data_out holds a completed block.
REQ-010 out_ready  input  1  consumer takes data_out.
REQ-011 data_out  output  64  result block.
REQ-012 error  output  1  one-cycle pulse when a pass times out.
REQ-013 des_start  output  1  one-cycle pulse launching the shared single-DES engine.
REQ-014 des_data  output  64  engine input block.
REQ-015 des_key  output  64  engine key.
REQ-016 des_decrypt  output  1  engine direction.
REQ-017 des_done  input  1  engine completion pulse.
REQ-018 des_result  input  64  engine output, valid when des_done=1.

Function
REQ-019 States: IDLE, START, WAIT, OUTPUT; pass counter 0..2.
REQ-020 in_ready=1 only in IDLE; handshake = in_valid & in_ready; on handshake, data_in, keys and decrypt are captured into internal registers, pass=0, next state START.
REQ-021 START: des_start=1 for exactly one cycle, des_data/des_key/des_decrypt driven from registers, next WAIT; des_data/des_key/des_decrypt stay stable until des_done.
REQ-022 Pass schedule, encrypt: (E,key_1),(D,key_2),(E,key_3); decrypt: (D,key_3),(E,key_2),(D,key_1).
REQ-023 WAIT + des_done: des_result loaded into the block register; pass<2 -> pass+1, START; pass=2 -> OUTPUT.
REQ-024 des_done outside WAIT is ignored.
REQ-025 OUTPUT: out_valid=1, data_out=block register; on out_valid & out_ready -> IDLE; data_out stays stable while stalled.
REQ-026 Latency from handshake to out_valid = 3 x (engine latency + 1) + 1 cycles; accept-to-accept spacing is never below that plus 1.
REQ-027 WAIT counter counts cycles since des_start; reaching DONE_TIMEOUT without des_done -> error pulse, block discarded, return to IDLE, no out_valid.
REQ-028 in_valid while busy is neither accepted nor lost upstream (in_ready=0 holds it).
REQ-029 in_valid and out_ready both high in OUTPUT: only the output completes; new block accepted in the following IDLE cycle.

Reset
REQ-030 rst_n low, asynchronously: state IDLE, pass 0, timeout counter 0, in_ready becomes 1 after release, out_valid=0, des_start=0, error=0, data_out/des_data/des_key=0, des_decrypt=0.
REQ-031 Reset mid-operation abandons the block with no output; a late des_done after reset is ignored.

Structure
REQ-032 Shared package tdes_pkg holds the state enumeration, pass-index type and DES_BLOCK_W=64 / DES_KEY_W=64 constants.
REQ-033 The single-DES engine is a separate module, des_core, outside this block; the sequencer has no sub-modules.

Verification (bench uses a behavioural des_core model with configurable latency)
REQ-034 key_1=key_2=key_3=133457799BBCDFF1, data_in=0123456789ABCDEF, decrypt=0 -> data_out=85E813540F0AB405 (degenerates to single DES).
REQ-035 Same keys, data_in=85E813540F0AB405, decrypt=1 -> data_out=0123456789ABCDEF; des_key order key_3, key_2, key_1 with D, E, D.
REQ-036 Engine latency 5, key_1=9474B8E8C73BCA7D, key_2=8DA744E0C94E5E17, key_3=0CDB25E3BA3C6D79 -> exactly three des_start pulses, out_valid 19 cycles after handshake, result matches the model.
REQ-037 out_ready held low 10 cycles in OUTPUT -> out_valid and data_out stable, in_ready=0, in_valid ignored throughout.
REQ-038 Engine never asserts des_done, DONE_TIMEOUT=64 -> error pulse 64 cycles after des_start, no out_valid, in_ready=1 next cycle.
REQ-039 rst_n low during pass 1 WAIT, then des_done -> no out_valid, all outputs at reset values, next block processed correctly.
